// File: rtl/div_unit_pkg.sv
// Shared widths, FSM state encodings and handshake levels for the iterative divider.
package div_unit_pkg;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

   localparam logic [RegBus-1:0] ZeroWord = '0;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor magnitude from the
// partial remainder, then shift in the next quotient bit.
module div_step
   import div_unit_pkg::*;
(
   input  logic [DoubleRegBus-1:0] i_dividend,
   input  logic [RegBus-1:0]       i_divisor,
   output logic [DoubleRegBus:0]   o_dividend
);

   logic [RegBus:0] w_diff;

   assign w_diff = {1'b0, i_dividend[DoubleRegBus-1:RegBus]} - {1'b0, i_divisor};

   // Keep bit 63 on the shift: on the last step the remainder can need all 32 bits.
   assign o_dividend = w_diff[RegBus] ? {i_dividend, 1'b0}
                                      : {w_diff[RegBus-1:0], i_dividend[RegBus-1:0], 1'b1};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU, returning {remainder, quotient}.
// Optional macro DIV_EARLY_EXIT_EN finishes in two cycles when |dividend| < |divisor|.
module div_unit
   import div_unit_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    signed_div_i,
   input  logic [RegBus-1:0]       opdata1_i,
   input  logic [RegBus-1:0]       opdata2_i,
   input  logic                    start_i,
   input  logic                    annul_i,
   output logic [DoubleRegBus-1:0] result_o,
   output logic                    ready_o
);

   div_state_t              r_state;
   logic [5:0]              r_cnt;
   logic [DoubleRegBus:0]   r_dividend;
   logic [RegBus-1:0]       r_divisor_mag;
   logic                    r_neg_quot;
   logic                    r_neg_rem;

   logic [RegBus-1:0]       w_op1_mag;
   logic [RegBus-1:0]       w_op2_mag;
   logic [DoubleRegBus:0]   w_step;
   logic [RegBus-1:0]       w_quot;
   logic [RegBus-1:0]       w_rem;

   assign w_op1_mag = (signed_div_i && opdata1_i[RegBus-1]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_op2_mag = (signed_div_i && opdata2_i[RegBus-1]) ? (~opdata2_i + 32'd1) : opdata2_i;

   div_step u_step (
      .i_dividend (r_dividend[DoubleRegBus-1:0]),
      .i_divisor  (r_divisor_mag),
      .o_dividend (w_step)
   );

   assign w_quot = r_neg_quot ? (~r_dividend[RegBus-1:0] + 32'd1) : r_dividend[RegBus-1:0];
   assign w_rem  = r_neg_rem  ? (~r_dividend[DoubleRegBus:RegBus+1] + 32'd1)
                              : r_dividend[DoubleRegBus:RegBus+1];

   // NOTE: state and outputs update together on the edge, so every assignment here is non-blocking.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= DivFree;
         r_cnt         <= '0;
         r_dividend    <= '0;
         r_divisor_mag <= ZeroWord;
         r_neg_quot    <= 1'b0;
         r_neg_rem     <= 1'b0;
         result_o      <= {ZeroWord, ZeroWord};
         ready_o       <= DivResultNotReady;
      end else begin
         case (r_state)
            DivFree: begin
               result_o <= {ZeroWord, ZeroWord};
               ready_o  <= DivResultNotReady;
               if (start_i == DivStart && !annul_i) begin
                  r_divisor_mag <= w_op2_mag;
                  r_neg_quot    <= signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
                  r_neg_rem     <= signed_div_i & opdata1_i[RegBus-1];
                  r_cnt         <= '0;
                  if (opdata2_i == ZeroWord) begin
                     r_state <= DivByZero;
`ifdef DIV_EARLY_EXIT_EN
                  end else if (w_op1_mag < w_op2_mag) begin
                     // Preload the finished form; the DivOn exit applies sign correction next edge.
                     r_dividend <= {w_op1_mag, 33'd0};
                     r_cnt      <= 6'd32;
                     r_state    <= DivOn;
`endif
                  end else begin
                     r_dividend <= {32'd0, w_op1_mag, 1'b0};
                     r_state    <= DivOn;
                  end
               end
            end
            DivByZero: begin
               r_dividend <= '0;
               result_o   <= {ZeroWord, ZeroWord};
               ready_o    <= DivResultReady;
               r_state    <= DivEnd;
            end
            DivOn: begin
               if (start_i == DivStop || annul_i) begin
                  r_cnt    <= '0;
                  result_o <= {ZeroWord, ZeroWord};
                  ready_o  <= DivResultNotReady;
                  r_state  <= DivFree;
               end else if (r_cnt == 6'd32) begin
                  r_cnt    <= '0;
                  result_o <= {w_rem, w_quot};
                  ready_o  <= DivResultReady;
                  r_state  <= DivEnd;
               end else begin
                  r_dividend <= w_step;
                  r_cnt      <= r_cnt + 6'd1;
               end
            end
            DivEnd: begin
               if (start_i == DivStop) begin
                  result_o <= {ZeroWord, ZeroWord};
                  ready_o  <= DivResultNotReady;
                  r_state  <= DivFree;
               end
            end
            default: r_state <= DivFree;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus queues expected {remainder, quotient} and latency,
// a negedge monitor pops and compares whenever ready_o rises.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   always #5 clk = ~clk;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          e0;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [63:0] last_res = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Plain integer division: quotient truncates toward zero, remainder takes the dividend's sign.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Edges from the start-sampling edge to the edge that raises ready_o (34 cycles of stall).
   function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
`ifdef DIV_EARLY_EXIT_EN
      longint sa, sb;
`endif
      if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (sa < 0) sa = -sa;
      if (sb < 0) sb = -sb;
      if (sa < sb) return 1;
`else
      if (sgn) return 33;
`endif
      return 33;
   endfunction

   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else begin
            if (ready_o && !prev) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_ready", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("result", result_o, e.res);
                  check("latency", 64'(cyc - e.e0), 64'(e.lat));
                  last_res = e.res;
               end
            end else if (ready_o && prev) begin
               check("hold_result", result_o, last_res);
            end else if (!ready_o && prev) begin
               check("clear_result", result_o, 64'd0);
            end
            prev = ready_o;
         end
      end
   end

   // abort_kind: 0 = run to completion, 1 = annul_i, 2 = rst; abort sampled when cnt == abort_at.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int hold, input int abort_kind, input int abort_at);
      exp_t e;
      int   n;
      bit   rose;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = sgn;
      start_i      = 1'b1;
      if (abort_kind == 0) begin
         e.res = ref_div(a, b, sgn);
         e.lat = ref_lat(a, b, sgn);
         e.e0  = cyc + 1;
         exp_q.push_back(e);
         n = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
         end while (!ready_o && n < 80);
         if (!ready_o) begin
            check("ready_timeout", 64'd0, 64'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            start_i = 1'b0;
            @(posedge clk);
            #1;
         end else begin
            repeat (hold) begin
               @(posedge clk);
               #1;
            end
            start_i = 1'b0;
            @(posedge clk);
            #1;
            check("drop_ready", {63'd0, ready_o}, 64'd0);
            check("drop_result", result_o, 64'd0);
         end
      end else begin
         @(posedge clk);
         #1;
         repeat (abort_at) begin
            @(posedge clk);
            #1;
         end
         if (abort_kind == 1) annul_i = 1'b1;
         else rst = 1'b1;
         @(posedge clk);
         #1;
         check("abort_ready", {63'd0, ready_o}, 64'd0);
         check("abort_result", result_o, 64'd0);
         annul_i = 1'b0;
         rst     = 1'b0;
         start_i = 1'b0;
         rose    = 1'b0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) rose = 1'b1;
         end
         check("abort_no_ready", {63'd0, rose}, 64'd0);
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [31:0] corners [5];
      logic [31:0] a, b;
      int          mode;
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h7FFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'hFFFF_FFFF;

      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {63'd0, ready_o}, 64'd0);
      check("reset_result", result_o, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_div(32'd100, 32'd7, 1'b0, 0, 0, 0);
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 0);
      run_div(32'h0000_1234, 32'd0, 1'b0, 0, 0, 0);
      run_div(32'h0000_0055, 32'd3, 1'b1, 0, 1, 10);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
      run_div(32'd1000, 32'd13, 1'b0, 3, 0, 0);
      run_div(32'h00AB_CDEF, 32'd5, 1'b0, 0, 2, 20);
      run_div(32'd9, 32'd3, 1'b0, 0, 0, 0);
      run_div(32'h8000_0000, 32'h8000_0001, 1'b0, 0, 0, 0);
      run_div(32'd5, 32'hFFFF_FFFD, 1'b1, 1, 0, 0);

      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 4);
         a    = $urandom();
         b    = $urandom();
         case (mode)
            1:       b = $urandom_range(1, 15);
            2:       b = 32'd0;
            3:       b = b | 32'h8000_0000;
            4: begin
               a = corners[$urandom_range(0, 4)];
               b = corners[$urandom_range(0, 4)];
            end
            default: ;
         endcase
         run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 0);
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
